// File: rtl/program_loader.sv
// program_loader: boot-time loader that packs a byte stream into 15-bit
// instruction words, writes them sequentially into instruction SRAM over the
// core's WA/WD/WE port, then raises PC_en so the core starts executing.
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// (LOAD_CK state) that must match before the core is released.
module program_loader #(
  parameter int DEPTH = 7,
  parameter int AW    = 3,
  parameter int DW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] word_count,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  output logic [AW-1:0] WA,
  output logic [DW-1:0] WD,
  output logic          WE,
  output logic          PC_en,
  output logic          busy,
  output logic          done,
  output logic          err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    WRITE   = 3'd3,
    RUN     = 3'd4,
    LOAD_CK = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    WRITE   = 3'd3,
    RUN     = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    lo_byte_q, lo_byte_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          in_ready_q, in_ready_d;
  logic [AW-1:0] WA_q, WA_d;
  logic [DW-1:0] WD_q, WD_d;
  logic          WE_q, WE_d;
  logic          PC_en_q, PC_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Session events produced by the next-state logic, consumed by output logic
  logic          hs;
  logic          count_legal;
  logic          start_ok;
  logic          start_bad;
  logic          hi_bad;
  logic          ck_bad;
  logic [AW-1:0] last_addr;

  assign count_legal = (word_count != '0) && (int'(word_count) <= DEPTH);
  assign last_addr   = count_q - AW'(1);

  // State register and all registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      lo_byte_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
      in_ready_q <= 1'b0;
      WA_q       <= '0;
      WD_q       <= '0;
      WE_q       <= 1'b0;
      PC_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      lo_byte_q  <= lo_byte_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
      in_ready_q <= in_ready_d;
      WA_q       <= WA_d;
      WD_q       <= WD_d;
      WE_q       <= WE_d;
      PC_en_q    <= PC_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: session sequencing, address/byte bookkeeping, events
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    lo_byte_d = lo_byte_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    start_ok  = 1'b0;
    start_bad = 1'b0;
    hi_bad    = 1'b0;
    ck_bad    = 1'b0;
    hs        = in_valid && in_ready_q;

    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          if (count_legal) begin
            start_ok = 1'b1;
            count_d  = word_count;
            addr_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d   = '0;
`endif
            state_d  = LOAD_LO;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      LOAD_LO: begin
        if (hs) begin
          lo_byte_d = in_byte;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ in_byte;
`endif
          state_d   = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (hs) begin
          if (in_byte[7]) begin
            hi_bad  = 1'b1;
            state_d = IDLE;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ in_byte;
`endif
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (addr_q == last_addr) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = LOAD_CK;
`else
          state_d = RUN;
`endif
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = LOAD_LO;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      LOAD_CK: begin
        if (hs) begin
          if (in_byte == csum_q) begin
            state_d = RUN;
          end else begin
            ck_bad  = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic: flop inputs are decoded from the next state so every
  // output is a register that already reflects the state it belongs to
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    WE_d       = 1'b0;
    PC_en_d    = 1'b0;
    WA_d       = WA_q;
    WD_d       = WD_q;
    err_d      = err_q;
    done_d     = done_q;

    case (state_d)
      LOAD_LO, LOAD_HI: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      WRITE: begin
        WE_d   = 1'b1;
        busy_d = 1'b1;
      end
      RUN: begin
        PC_en_d = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      LOAD_CK: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
`endif
      default: ;
    endcase

    if (state_q == LOAD_HI && state_d == WRITE) begin
      WA_d = addr_q;
      WD_d = DW'({in_byte[6:0], lo_byte_q});
    end

    if (start_ok) begin
      err_d  = 1'b0;
      done_d = 1'b0;
    end
    if (start_bad || hi_bad || ck_bad) begin
      err_d = 1'b1;
    end
    if (ck_bad) begin
      done_d = 1'b0;
    end
    if (state_d == RUN) begin
      done_d = 1'b1;
    end
  end

  assign in_ready = in_ready_q;
  assign WA       = WA_q;
  assign WD       = WD_q;
  assign WE       = WE_q;
  assign PC_en    = PC_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
